// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
//   Bundles the write-back arbiter's bus signals.
//   slave  : the arbiter. Takes requests, issue/check info; drives grants,
//            hazard and the register-file write port.
//   master : the surrounding core (execution units, issue stage, regfile).
//   Requester-indexed fields are flat vectors. Requester i owns
//   req_reg[i*REGW +: REGW] and req_data[i*XLEN +: XLEN].
//   Parameters must match those of the wb_port_arbiter instance.
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  // write-back requesters
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_fmode;
  logic [NREQ*REGW-1:0] req_reg;
  logic [NREQ*XLEN-1:0] req_data;
  // issue-stage allocation
  logic                 iss_valid;
  logic                 iss_fmode;
  logic [REGW-1:0]      iss_reg;
  // hazard check
  logic                 chk_fmode;
  logic [REGW-1:0]      chk_rs1;
  logic [REGW-1:0]      chk_rs2;
  logic [REGW-1:0]      chk_rd;
  logic                 hazard;
  // register-file write port
  logic                 wenable;
  logic                 wfmode;
  logic [REGW-1:0]      wreg;
  logic [XLEN-1:0]      wdata;

  modport slave (
    input  req_valid, req_fmode, req_reg, req_data,
    input  iss_valid, iss_fmode, iss_reg,
    input  chk_fmode, chk_rs1, chk_rs2, chk_rd,
    output req_ready, hazard,
    output wenable, wfmode, wreg, wdata
  );

  modport master (
    output req_valid, req_fmode, req_reg, req_data,
    output iss_valid, iss_fmode, iss_reg,
    output chk_fmode, chk_rs1, chk_rs2, chk_rd,
    input  req_ready, hazard,
    input  wenable, wfmode, wreg, wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port among NREQ write-back
//   requesters. Arbitration is round-robin and the write port is registered.
//   Also keeps a 2 x 2**REGW scoreboard of pending destinations, split into
//   an int file and an fp file, and flags RAW/WAW hazards for issue.
//
// Ports
//   clk   : clock, all state on the rising edge
//   rstn  : asynchronous active-low reset
//   bus   : wb_port_arbiter_if.slave
//           req_*  requester handshake; req_ready is a one-hot grant
//           iss_*  destination allocated by issue (sets a busy bit)
//           chk_*  operands of the instruction being checked
//           hazard any checked register busy (combinational)
//           w*     register-file write port (registered)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  wb_port_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 1 << REGW;

  // (base + off) mod NREQ. base < NREQ and off < NREQ, so one subtract is enough.
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // ------------------------------------------------------------------------
  // Round-robin grant
  // ------------------------------------------------------------------------
  logic [PW-1:0]   r_ptr;
  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_xfer;
  logic            w_sel_fm;
  logic [REGW-1:0] w_sel_reg;
  logic [XLEN-1:0] w_sel_data;

  // The first valid requester, scanning from r_ptr, wins the port.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_vld && bus.req_valid[f_wrap(r_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = f_wrap(r_ptr, k);
      end
    end
  end

  // Gating with rstn keeps req_ready low for the whole reset. Without it a
  // requester could see a grant that the held registers never take.
  assign w_xfer = w_gnt_vld & rstn;

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign bus.req_ready[i] = w_xfer & (w_gnt_idx == PW'(i));
  end

  assign w_sel_fm   = bus.req_fmode[w_gnt_idx];
  assign w_sel_reg  = bus.req_reg[int'(w_gnt_idx)*REGW +: REGW];
  assign w_sel_data = bus.req_data[int'(w_gnt_idx)*XLEN +: XLEN];

  // ------------------------------------------------------------------------
  // Registered write port
  // ------------------------------------------------------------------------
  logic            r_wen;
  logic            r_wf;
  logic [REGW-1:0] r_wreg;
  logic [XLEN-1:0] r_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_wen   <= 1'b0;
      r_wf    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_xfer) begin
      r_ptr   <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
      r_wf    <= w_sel_fm;
      r_wreg  <= w_sel_reg;
      r_wdata <= w_sel_data;
      // A write to int x0 is accepted and dropped. fp f0 is a real register.
      r_wen   <= w_sel_fm | (|w_sel_reg);
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign bus.wenable = r_wen;
  assign bus.wfmode  = r_wf;
  assign bus.wreg    = r_wreg;
  assign bus.wdata   = r_wdata;

  // ------------------------------------------------------------------------
  // Scoreboard: r_busy[file][index]
  // ------------------------------------------------------------------------
  logic [1:0][NR-1:0] r_busy;
  logic [1:0][NR-1:0] w_busy_nxt;
  logic               w_iss_set;

  // int x0 is never marked busy, so it can never raise a hazard.
  assign w_iss_set = bus.iss_valid & (bus.iss_fmode | (|bus.iss_reg));

  // Clear on the cycle the regfile is actually written. A set applied after
  // the clear wins when both hit the same bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen)     w_busy_nxt[r_wf][r_wreg] = 1'b0;
    if (w_iss_set) w_busy_nxt[bus.iss_fmode][bus.iss_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Reads registered state only. A write landing this cycle still reports busy.
  assign bus.hazard = r_busy[bus.chk_fmode][bus.chk_rs1]
                    | r_busy[bus.chk_fmode][bus.chk_rs2]
                    | r_busy[bus.chk_fmode][bus.chk_rd];

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .REGW(REGW)) bus ();

  wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .REGW(REGW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: spec-level state
  int          m_ptr;
  bit          m_busy [2][32];
  bit          m_wen, m_wf;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          last_g;
  bit          pend [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit f, input logic [4:0] r, input logic [31:0] d);
    bus.req_valid[i]           = v;
    bus.req_fmode[i]           = f;
    bus.req_reg[i*REGW +: REGW] = r;
    bus.req_data[i*XLEN +: XLEN] = d;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++)
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wen = 0; m_wf = 0; m_wreg = 0; m_wdata = 0;
    foreach (m_busy[f, r]) m_busy[f][r] = 0;
  endtask

  // Called just after a negedge with inputs already driven. Returns on the next negedge.
  task automatic cycle();
    int g;
    #1;
    g = exp_grant();
    chk("req_ready", bus.req_ready, (g < 0) ? 64'd0 : 64'(1 << g));
    chk("hazard", bus.hazard, m_busy[bus.chk_fmode][bus.chk_rs1] | m_busy[bus.chk_fmode][bus.chk_rs2]
                              | m_busy[bus.chk_fmode][bus.chk_rd]);
    if (bus.iss_valid) chk("iss_legal", m_busy[bus.iss_fmode][bus.iss_reg], 0);
    @(posedge clk);
    if (m_wen) m_busy[m_wf][m_wreg] = 0;
    if (bus.iss_valid && !(bus.iss_fmode == 0 && bus.iss_reg == 0)) m_busy[bus.iss_fmode][bus.iss_reg] = 1;
    if (g >= 0) begin
      m_ptr   = (g + 1) % NREQ;
      m_wf    = bus.req_fmode[g];
      m_wreg  = bus.req_reg[g*REGW +: REGW];
      m_wdata = bus.req_data[g*XLEN +: XLEN];
      m_wen   = !(m_wf == 0 && m_wreg == 0);
    end else m_wen = 0;
    last_g = g;
    #1;
    chk("wenable", bus.wenable, m_wen);
    chk("wfmode",  bus.wfmode,  m_wf);
    chk("wreg",    bus.wreg,    m_wreg);
    chk("wdata",   bus.wdata,   m_wdata);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse, called just after a negedge
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_ready",   bus.req_ready, 0);
    chk("rst_wenable", bus.wenable, 0);
    chk("rst_wreg",    bus.wreg, 0);
    chk("rst_wdata",   bus.wdata, 0);
    chk("rst_hazard",  bus.hazard, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic clr_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    bus.iss_valid = 0; bus.iss_fmode = 0; bus.iss_reg = 0;
    bus.chk_fmode = 0; bus.chk_rs1 = 0; bus.chk_rs2 = 0; bus.chk_rd = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 5'(i + 1), 32'hA0 + i);
    rstn = 1'b0;
    #2;
    chk("rst0_ready",   bus.req_ready, 0);
    chk("rst0_wenable", bus.wenable, 0);
    chk("rst0_wreg",    bus.wreg, 0);
    chk("rst0_wdata",   bus.wdata, 0);
    chk("rst0_hazard",  bus.hazard, 0);
    @(negedge clk);
    rstn = 1'b1;
    clr_reqs();

    // Single request
    set_req(0, 1, 0, 5, 32'hDEADBEEF);
    #1 chk("single_ready", bus.req_ready, 3'b001);
    cycle();
    chk("single_wen",   bus.wenable, 1);
    chk("single_wreg",  bus.wreg, 5);
    chk("single_wdata", bus.wdata, 32'hDEADBEEF);
    clr_reqs();
    cycle();
    chk("single_wen_off", bus.wenable, 0);

    // Fairness from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 5'(10 + i), 32'h100 + i);
    for (int k = 0; k < 6; k++) begin
      #1 chk("fair_ready", bus.req_ready, 64'(1 << (k % 3)));
      cycle();
      chk("fair_wreg", bus.wreg, 64'(10 + k % 3));
    end
    clr_reqs();

    // int x0 is consumed without a write; fp f0 is written
    set_req(1, 1, 0, 0, 32'h1234);
    #1 chk("x0_ready", bus.req_ready, 3'b010);
    cycle();
    chk("x0_wen", bus.wenable, 0);
    set_req(1, 1, 1, 0, 32'h5678);
    cycle();
    chk("f0_wen", bus.wenable, 1);
    chk("f0_wfmode", bus.wfmode, 1);
    clr_reqs();

    // Scoreboard lifetime of int 7
    bus.iss_valid = 1; bus.iss_fmode = 0; bus.iss_reg = 7;
    bus.chk_fmode = 0; bus.chk_rs1 = 7;
    cycle();
    bus.iss_valid = 0;
    #1 chk("sb_int7", bus.hazard, 1);
    bus.chk_fmode = 1;
    #1 chk("sb_fp7", bus.hazard, 0);
    bus.chk_fmode = 0;
    set_req(2, 1, 0, 7, 32'h77);
    #1 chk("sb_t1", bus.hazard, 1);
    cycle();
    clr_reqs();
    #1 chk("sb_t1p1", bus.hazard, 1);
    cycle();
    #1 chk("sb_t1p2", bus.hazard, 0);

    // Issue int 3 on the edge that writes int 3: the set wins
    set_req(0, 1, 0, 3, 32'h33);
    cycle();
    clr_reqs();
    bus.iss_valid = 1; bus.iss_fmode = 0; bus.iss_reg = 3; bus.chk_rs1 = 3;
    cycle();
    bus.iss_valid = 0;
    #1 chk("collide_hazard", bus.hazard, 1);

    // Reset during a burst
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 5'(20 + i), 32'h200 + i);
    cycle();
    cycle();
    do_reset();
    #1 chk("resume_ready", bus.req_ready, 3'b001);
    cycle();
    clr_reqs();

    // Randomized traffic against the model
    foreach (pend[i]) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && ($urandom % 2 == 1)) begin
          pend[i] = 1;
          set_req(i, 1, 1'($urandom), 5'($urandom), $urandom);
        end
      begin
        bit f; logic [4:0] r;
        f = 1'($urandom); r = 5'($urandom);
        bus.iss_valid = ($urandom % 3 == 0) && !m_busy[f][r];
        bus.iss_fmode = f; bus.iss_reg = r;
      end
      bus.chk_fmode = 1'($urandom);
      bus.chk_rs1 = 5'($urandom); bus.chk_rs2 = 5'($urandom); bus.chk_rd = 5'($urandom);
      if (c == 200) begin
        bus.iss_valid = 0;
        do_reset();
      end else begin
        cycle();
        if (last_g >= 0) begin
          pend[last_g] = 0;
          set_req(last_g, 0, 0, 0, 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
